// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit address I2C target with oversampled, filtered scl/sda.
// Define I2C_SLAVE_GEN_CALL_EN to ACK general-call writes (adds o_gen_call).
module i2c_slave #(
  parameter logic [6:0] G_SLV_ADDR  = 7'h50,
  parameter int         G_NB_FILTER = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] i_wdata,
  output logic       o_wdata_req,
  output logic [7:0] o_rdata,
  output logic       o_rdata_valid,
  output logic       o_rw,
  output logic       o_busy,
  output logic       o_start,
  output logic       o_stop
`ifdef I2C_SLAVE_GEN_CALL_EN
  ,
  output logic       o_gen_call
`endif
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  localparam logic [3:0] FLT_MAX = 4'(G_NB_FILTER - 1);

  // lane 1 = scl, lane 0 = sda
  logic [1:0] pin, s1, s2, flt, prv;
  logic [3:0] fcnt [2];

  assign pin = {scl, sda};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= '1;
      s2      <= '1;
      flt     <= '1;
      prv     <= '1;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      s1  <= pin;
      s2  <= s1;
      prv <= flt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == flt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FLT_MAX) begin
          flt[i]  <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = flt[1] & ~prv[1];
  assign scl_fall  = ~flt[1] & prv[1];
  assign start_det = flt[1] & prv[1] & prv[0] & ~flt[0];
  assign stop_det  = flt[1] & prv[1] & ~prv[0] & flt[0];

  state_t     state, state_d;
  logic [3:0] bcnt, bcnt_d;
  logic [7:0] sh, sh_d;
  logic [7:0] rdata, rdata_d;
  logic       oe, oe_d;
  logic       rw, rw_d;
  logic       busy, busy_d;
  logic       valid, valid_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       req;
  logic [7:0] byte_in;
  logic       own_hit;
`ifdef I2C_SLAVE_GEN_CALL_EN
  logic       gc, gc_d;
`endif

  assign byte_in = {sh[6:0], flt[0]};
  assign own_hit = (byte_in[7:1] == G_SLV_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bcnt    <= '0;
      sh      <= '0;
      rdata   <= '0;
      oe      <= 1'b0;
      rw      <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
`ifdef I2C_SLAVE_GEN_CALL_EN
      gc      <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      bcnt    <= bcnt_d;
      sh      <= sh_d;
      rdata   <= rdata_d;
      oe      <= oe_d;
      rw      <= rw_d;
      busy    <= busy_d;
      valid   <= valid_d;
      start_q <= start_d;
      stop_q  <= stop_d;
`ifdef I2C_SLAVE_GEN_CALL_EN
      gc      <= gc_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    bcnt_d  = bcnt;
    sh_d    = sh;
    rdata_d = rdata;
    oe_d    = oe;
    rw_d    = rw;
    busy_d  = busy;
    valid_d = 1'b0;
    start_d = 1'b0;
    stop_d  = 1'b0;
    req     = 1'b0;
`ifdef I2C_SLAVE_GEN_CALL_EN
    gc_d    = gc;
`endif
    if (start_det) begin
      state_d = ADDR;
      bcnt_d  = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      start_d = 1'b1;
`ifdef I2C_SLAVE_GEN_CALL_EN
      gc_d    = 1'b0;
`endif
    end else if (stop_det) begin
      state_d = IDLE;
      bcnt_d  = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      stop_d  = 1'b1;
`ifdef I2C_SLAVE_GEN_CALL_EN
      gc_d    = 1'b0;
`endif
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise) begin
            sh_d   = byte_in;
            bcnt_d = bcnt + 4'd1;
            if (bcnt == 4'd7) begin
              bcnt_d = '0;
              if (own_hit) begin
                state_d = ADDR_ACK;
                rw_d    = flt[0];
              end
`ifdef I2C_SLAVE_GEN_CALL_EN
              else if (byte_in == 8'h00) begin
                state_d = ADDR_ACK;
                rw_d    = 1'b0;
                gc_d    = 1'b1;
              end
`endif
              else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK: begin
          // bcnt marks whether the ACK is already on the bus
          if (scl_fall) begin
            if (bcnt == 4'd0) begin
              oe_d   = 1'b1;
              bcnt_d = 4'd1;
            end else begin
              bcnt_d = '0;
              busy_d = 1'b1;
              if (rw) begin
                req     = 1'b1;
                sh_d    = i_wdata;
                oe_d    = ~i_wdata[7];
                state_d = TX;
              end else begin
                oe_d    = 1'b0;
                state_d = RX;
              end
            end
          end
        end
        RX: begin
          if (scl_rise) begin
            sh_d   = byte_in;
            bcnt_d = bcnt + 4'd1;
            if (bcnt == 4'd7) begin
              rdata_d = byte_in;
              valid_d = 1'b1;
              bcnt_d  = '0;
              state_d = RX_ACK;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            if (bcnt == 4'd0) begin
              oe_d   = 1'b1;
              bcnt_d = 4'd1;
            end else begin
              oe_d    = 1'b0;
              bcnt_d  = '0;
              state_d = RX;
            end
          end
        end
        TX: begin
          if (scl_rise) begin
            sh_d   = {sh[6:0], 1'b0};
            bcnt_d = bcnt + 4'd1;
          end else if (scl_fall) begin
            if (bcnt == 4'd8) begin
              oe_d    = 1'b0;
              bcnt_d  = '0;
              state_d = TX_ACK;
            end else begin
              oe_d = ~sh[7];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (flt[0]) begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end else begin
              bcnt_d = 4'd1;
            end
          end else if (scl_fall && bcnt == 4'd1) begin
            req     = 1'b1;
            sh_d    = i_wdata;
            oe_d    = ~i_wdata[7];
            bcnt_d  = '0;
            state_d = TX;
          end
        end
        IDLE, WAIT_STOP: begin
          oe_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign sda           = oe ? 1'b0 : 1'bz;
  assign o_wdata_req   = req;
  assign o_rdata       = rdata;
  assign o_rdata_valid = valid;
  assign o_rw          = rw;
  assign o_busy        = busy;
  assign o_start       = start_q;
  assign o_stop        = stop_q;
`ifdef I2C_SLAVE_GEN_CALL_EN
  assign o_gen_call    = gc;
`endif

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed I2C master model driving i2c_slave,
// scoreboard queues for written and read bytes.
module tb_i2c_slave;

  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic [7:0] i_wdata = 8'h00;
  wire        sda;
  logic       o_wdata_req;
  logic [7:0] o_rdata;
  logic       o_rdata_valid;
  logic       o_rw;
  logic       o_busy;
  logic       o_start;
  logic       o_stop;
`ifdef I2C_SLAVE_GEN_CALL_EN
  logic       o_gen_call;
`endif

  int total = 0;
  int bad = 0;
  int n_start = 0;
  int n_stop = 0;
  int n_req = 0;
  int n_valid = 0;
  logic [7:0] wr_q[$];
  logic [7:0] rd_q[$];

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave #(
    .G_SLV_ADDR (7'h50),
    .G_NB_FILTER(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl          (scl),
    .sda          (sda),
    .i_wdata      (i_wdata),
    .o_wdata_req  (o_wdata_req),
    .o_rdata      (o_rdata),
    .o_rdata_valid(o_rdata_valid),
    .o_rw         (o_rw),
    .o_busy       (o_busy),
    .o_start      (o_start),
    .o_stop       (o_stop)
`ifdef I2C_SLAVE_GEN_CALL_EN
    ,
    .o_gen_call   (o_gen_call)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // write-side scoreboard and pulse counters
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_start) n_start++;
      if (o_stop) n_stop++;
      if (o_wdata_req) n_req++;
      if (o_rdata_valid) begin
        n_valid++;
        chk1("valid_expected", wr_q.size() != 0, 1'b1);
        if (wr_q.size() != 0) chk8("rdata", o_rdata, wr_q.pop_front());
      end
    end
  end

  task automatic w(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic m_start();
    m_oe = 1'b1; w(Q);
    scl = 1'b0; w(Q);
  endtask

  task automatic m_rstart();
    m_oe = 1'b0; w(Q);
    scl = 1'b1; w(Q);
    m_oe = 1'b1; w(Q);
    scl = 1'b0; w(Q);
  endtask

  task automatic m_stop();
    m_oe = 1'b1; w(Q);
    scl = 1'b1; w(Q);
    m_oe = 1'b0; w(2 * Q);
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_oe = ~b; w(Q);
    scl = 1'b1; w(Q);
    r = sda; w(Q);
    scl = 1'b0; w(Q);
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(d[i], r);
    m_bit(1'b1, ack);
  endtask

  task automatic m_rbyte(output logic [7:0] d);
    for (int i = 7; i >= 0; i--) m_bit(1'b1, d[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] d;
    int         s0;

    // reset state
    w(4);
    @(negedge clk);
    chk8("rst_rdata", o_rdata, 8'h00);
    chk1("rst_rw", o_rw, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_valid", o_rdata_valid, 1'b0);
    chk1("rst_start", o_start, 1'b0);
    chk1("rst_sda", sda, 1'b1);
    rst_n = 1'b1;
    w(2 * Q);

    // write to own address
    m_start();
    m_wbyte(8'hA0, ack);
    chk1("wr_addr_ack", ack, 1'b0);
    chk1("wr_busy_on", o_busy, 1'b1);
    chk1("wr_rw", o_rw, 1'b0);
    wr_q.push_back(8'hA5);
    m_wbyte(8'hA5, ack);
    chk1("wr_d0_ack", ack, 1'b0);
    wr_q.push_back(8'h3C);
    m_wbyte(8'h3C, ack);
    chk1("wr_d1_ack", ack, 1'b0);
    m_stop();
    chk1("wr_busy_off", o_busy, 1'b0);
    chki("wr_nvalid", n_valid, 2);
    chki("wr_nstart", n_start, 1);
    chki("wr_nstop", n_stop, 1);
    chk8("wr_last", o_rdata, 8'h3C);

    // read from own address
    i_wdata = 8'h96;
    rd_q.push_back(8'h96);
    rd_q.push_back(8'h69);
    m_start();
    m_wbyte(8'hA1, ack);
    chk1("rd_addr_ack", ack, 1'b0);
    chk1("rd_rw", o_rw, 1'b1);
    m_rbyte(d);
    chk8("rd_b0", d, rd_q.pop_front());
    i_wdata = 8'h69;
    m_bit(1'b0, r);
    m_rbyte(d);
    chk8("rd_b1", d, rd_q.pop_front());
    m_bit(1'b1, r);
    chk1("rd_nack_seen", r, 1'b1);
    chk1("rd_sda_rel", sda, 1'b1);
    chk1("rd_busy_nack", o_busy, 1'b0);
    m_stop();
    chki("rd_nreq", n_req, 2);

    // address mismatch
    s0 = n_valid;
    m_start();
    m_wbyte(8'hA2, ack);
    chk1("mm_addr_nack", ack, 1'b1);
    chk1("mm_busy", o_busy, 1'b0);
    m_wbyte(8'h11, ack);
    chk1("mm_data_nack", ack, 1'b1);
    m_stop();
    chki("mm_novalid", n_valid, s0);

    // repeated start, write then read
    s0 = n_start;
    i_wdata = 8'hC3;
    rd_q.push_back(8'hC3);
    m_start();
    m_wbyte(8'hA0, ack);
    chk1("rs_wr_ack", ack, 1'b0);
    wr_q.push_back(8'h01);
    m_wbyte(8'h01, ack);
    chk1("rs_d_ack", ack, 1'b0);
    chk1("rs_rw0", o_rw, 1'b0);
    m_rstart();
    chk1("rs_busy_clr", o_busy, 1'b0);
    m_wbyte(8'hA1, ack);
    chk1("rs_rd_ack", ack, 1'b0);
    chk1("rs_rw1", o_rw, 1'b1);
    m_rbyte(d);
    chk8("rs_rdata", d, rd_q.pop_front());
    m_bit(1'b1, r);
    m_stop();
    chki("rs_nstart", n_start - s0, 2);

    // reset during bit 4 of a TX byte
    i_wdata = 8'h00;
    m_start();
    m_wbyte(8'hA1, ack);
    chk1("rr_addr_ack", ack, 1'b0);
    m_bit(1'b1, r);
    m_bit(1'b1, r);
    m_bit(1'b1, r);
    chk1("rr_bit5", r, 1'b0);
    m_oe = 1'b0;
    w(Q);
    chk1("rr_driving", sda, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk1("rr_sda_rel", sda, 1'b1);
    w(2);
    #1;
    chk1("rr_busy", o_busy, 1'b0);
    chk1("rr_rw", o_rw, 1'b0);
    chk8("rr_rdata", o_rdata, 8'h00);
    chk1("rr_req", o_wdata_req, 1'b0);
    rst_n = 1'b1;
    w(Q);
    m_stop();
    m_start();
    m_wbyte(8'hA0, ack);
    chk1("rr_again_ack", ack, 1'b0);
    wr_q.push_back(8'h77);
    m_wbyte(8'h77, ack);
    chk1("rr_d_ack", ack, 1'b0);
    m_stop();
    chk8("rr_rdata2", o_rdata, 8'h77);

    // general call
    m_start();
    m_wbyte(8'h00, ack);
`ifdef I2C_SLAVE_GEN_CALL_EN
    chk1("gc_ack", ack, 1'b0);
    chk1("gc_flag", o_gen_call, 1'b1);
    wr_q.push_back(8'h5A);
    m_wbyte(8'h5A, ack);
    chk1("gc_d_ack", ack, 1'b0);
    chk8("gc_rdata", o_rdata, 8'h5A);
    m_stop();
    chk1("gc_flag_off", o_gen_call, 1'b0);
`else
    chk1("gc_nack", ack, 1'b1);
    chk1("gc_busy", o_busy, 1'b0);
    m_stop();
`endif

    chki("wr_q_empty", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
